alu_seq_param: RTL and testbench

Parametrised sequential integer ALU, successor of the 8-bit four-operation ALU datapath. It performs add, subtract, signed radix-4 Booth multiply and unsigned non-restoring divide at a configurable word width. Operands stream in on a shared `inbus` and results stream out on `outbus`, framed by the existing `BEGIN`/`END` protocol. It sits directly under the top-level processor datapath, in place of the fixed-width ALU.

---
 rtl/alu_seq_param.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// Sequential add/sub/radix-4 Booth multiply/non-restoring divide on a shared WIDTH-bit bus, BEGIN/END framed.
// Define ALU_DIV_GUARD_EN to short-circuit divides whose quotient cannot fit (or divisor is zero) and flag err.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BEGIN,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             END,
  output logic             busy,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    LOAD3 = 3'd3,
    EXEC  = 3'd4,
    CORR  = 3'd5,
    OUT1  = 3'd6,
    OUT2  = 3'd7
  } state_t;

  state_t           state;
  logic [1:0]       op;
  logic [WIDTH-1:0] xreg;   // X (add/sub/mul), dividend high then divisor (div)
  logic [WIDTH-1:0] qreg;   // Y / low product (mul), dividend low / quotient (div)
  logic [WIDTH+1:0] acc;
  logic             prev;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  // add / sub
  logic [WIDTH-1:0] addsub;
  assign addsub = (op == OP_SUB) ? (xreg - qreg) : (xreg + qreg);

  // one radix-4 Booth step: add the recoded digit times X, then arithmetic shift {acc,qreg} by 2
  logic [WIDTH+1:0] x_ext;
  logic [WIDTH+1:0] x_dbl;
  logic [WIDTH+1:0] booth_add;
  logic [WIDTH+1:0] booth_sum;
  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH-1:0] mul_q_nxt;

  always_comb begin
    x_ext     = {{2{xreg[WIDTH-1]}}, xreg};
    x_dbl     = {x_ext[WIDTH:0], 1'b0};
    booth_add = '0;
    case ({qreg[1:0], prev})
      3'b001, 3'b010: booth_add = x_ext;
      3'b011:         booth_add = x_dbl;
      3'b100:         booth_add = '0 - x_dbl;
      3'b101, 3'b110: booth_add = '0 - x_ext;
      default:        booth_add = '0;
    endcase
    booth_sum = acc + booth_add;
    acc_nxt   = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
    mul_q_nxt = {booth_sum[1:0], qreg[WIDTH-1:2]};
  end

  // one non-restoring step; the WIDTH+1 bit wrap is harmless because the true remainder fits
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_rem_nxt;
  logic [WIDTH:0]   div_fix;
  logic [WIDTH-1:0] div_q_nxt;

  always_comb begin
    d_ext       = {1'b0, xreg};
    div_shift   = {rem[WIDTH-1:0], qreg[WIDTH-1]};
    div_rem_nxt = rem[WIDTH] ? (div_shift + d_ext) : (div_shift - d_ext);
    div_q_nxt   = {qreg[WIDTH-2:0], ~div_rem_nxt[WIDTH]};
    div_fix     = rem[WIDTH] ? (rem + d_ext) : rem;
  end

`ifdef ALU_DIV_GUARD_EN
  logic div_bad;
  assign div_bad = (inbus == '0) || (rem[WIDTH-1:0] >= inbus);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op     <= OP_ADD;
      xreg   <= '0;
      qreg   <= '0;
      acc    <= '0;
      prev   <= 1'b0;
      rem    <= '0;
      cnt    <= '0;
      outbus <= '0;
      END    <= 1'b0;
      busy   <= 1'b0;
`ifdef ALU_DIV_GUARD_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (BEGIN) begin
            op    <= op_code;
            busy  <= 1'b1;
            state <= LOAD1;
`ifdef ALU_DIV_GUARD_EN
            err   <= 1'b0;
`endif
          end
        end

        LOAD1: begin
          xreg  <= inbus;
          state <= LOAD2;
        end

        LOAD2: begin
          qreg  <= inbus;
          acc   <= '0;
          prev  <= 1'b0;
          cnt   <= '0;
          rem   <= {1'b0, xreg};
          state <= (op == OP_DIV) ? LOAD3 : EXEC;
        end

        LOAD3: begin
          xreg <= inbus;
          cnt  <= '0;
`ifdef ALU_DIV_GUARD_EN
          if (div_bad) begin
            qreg   <= '1;
            outbus <= '0;
            err    <= 1'b1;
            state  <= OUT1;
          end else begin
            state <= EXEC;
          end
`else
          state <= EXEC;
`endif
        end

        EXEC: begin
          case (op)
            OP_ADD, OP_SUB: begin
              outbus <= addsub;
              END    <= 1'b1;
              state  <= OUT1;
            end
            OP_MUL: begin
              acc  <= acc_nxt;
              qreg <= mul_q_nxt;
              prev <= qreg[1];
              cnt  <= cnt + 1'b1;
              if (cnt == MUL_LAST) begin
                outbus <= acc_nxt[WIDTH-1:0];
                state  <= OUT1;
              end
            end
            default: begin
              rem  <= div_rem_nxt;
              qreg <= div_q_nxt;
              cnt  <= cnt + 1'b1;
              if (cnt == DIV_LAST) state <= CORR;
            end
          endcase
        end

        CORR: begin
          rem    <= div_fix;
          outbus <= div_fix[WIDTH-1:0];
          state  <= OUT1;
        end

        OUT1: begin
          if (op == OP_ADD || op == OP_SUB) begin
            outbus <= '0;
            END    <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            outbus <= qreg;
            END    <= 1'b1;
            state  <= OUT2;
          end
        end

        OUT2: begin
          outbus <= '0;
          END    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed, table-driven bench for alu_seq_param at WIDTH=8; expectations follow ALU_DIV_GUARD_EN.
module tb_alu_seq_param;
  localparam int W = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;
`ifdef ALU_DIV_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op_code;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         done;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .BEGIN   (start),
    .op_code (op_code),
    .inbus   (inbus),
    .outbus  (outbus),
    .END     (done),
    .busy    (busy),
    .err     (err)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] w0, w1, w2;
    int         end_cyc;
    int         nwords;
    bit         chk_val;
    logic [7:0] r1, r2;
    logic       e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input int end_cyc, input int nwords,
                              input bit chk_val, input logic [7:0] r1, input logic [7:0] r2,
                              input logic e);
    vec_t v;
    v.op = op; v.w0 = w0; v.w1 = w1; v.w2 = w2;
    v.end_cyc = end_cyc; v.nwords = nwords; v.chk_val = chk_val;
    v.r1 = r1; v.r2 = r2; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered in cycle 0 (just after a rising edge); returns in the cycle after END,
  // which is the next transaction's cycle 0.
  task automatic run_vec(input int idx, input vec_t v);
    int         endc;
    logic [7:0] prev_out;
    logic       prev_err;
    endc     = -1;
    prev_out = '0;
    prev_err = 1'b0;
    start    = 1'b1;
    op_code  = v.op;
    inbus    = '0;
    for (int c = 1; c <= 40 && endc < 0; c++) begin
      prev_out = outbus;
      prev_err = err;
      @(posedge clk); #1;
      start = 1'b0;
      inbus = (c == 1) ? v.w0 : (c == 2) ? v.w1 : (c == 3) ? v.w2 : 8'h00;
      if (c == 1) check($sformatf("v%0d busy_cycle1", idx), busy, 1);
      if (done) begin
        endc = c;
        check($sformatf("v%0d err_at_end", idx), err, v.e);
        if (v.chk_val) begin
          if (v.nwords == 2) begin
            check($sformatf("v%0d out1", idx), prev_out, v.r1);
            check($sformatf("v%0d err_out1", idx), prev_err, v.e);
            check($sformatf("v%0d out2", idx), outbus, v.r2);
          end else begin
            check($sformatf("v%0d out", idx), outbus, v.r1);
          end
        end
      end
    end
    check($sformatf("v%0d end_cycle", idx), endc, v.end_cyc);
    @(posedge clk); #1;
    check($sformatf("v%0d busy_after", idx), busy, 0);
    check($sformatf("v%0d end_after", idx), done, 0);
    check($sformatf("v%0d outbus_after", idx), outbus, 0);
    check($sformatf("v%0d err_hold", idx), err, v.e);
  endtask

  initial begin
    tbl.push_back(mk(ADD, 8'h7F, 8'h01, 8'h00, 4, 1, 1, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(SUB, 8'h00, 8'h01, 8'h00, 4, 1, 1, 8'hFF, 8'h00, 1'b0));
    tbl.push_back(mk(ADD, 8'hFF, 8'hFF, 8'h00, 4, 1, 1, 8'hFE, 8'h00, 1'b0));
    tbl.push_back(mk(MUL, 8'hFD, 8'h05, 8'h00, 8, 2, 1, 8'hFF, 8'hF1, 1'b0));
    tbl.push_back(mk(MUL, 8'h80, 8'h80, 8'h00, 8, 2, 1, 8'h40, 8'h00, 1'b0));
    tbl.push_back(mk(MUL, 8'h7F, 8'h7F, 8'h00, 8, 2, 1, 8'h3F, 8'h01, 1'b0));
    tbl.push_back(mk(MUL, 8'h02, 8'hFD, 8'h00, 8, 2, 1, 8'hFF, 8'hFA, 1'b0));
    tbl.push_back(mk(DIV, 8'h00, 8'h64, 8'h07, 14, 2, 1, 8'h02, 8'h0E, 1'b0));
    tbl.push_back(GUARD ? mk(DIV, 8'h05, 8'h00, 8'h03, 5, 2, 1, 8'h00, 8'hFF, 1'b1)
                        : mk(DIV, 8'h05, 8'h00, 8'h03, 14, 2, 0, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(DIV, 8'h00, 8'hFF, 8'h10, 14, 2, 1, 8'h0F, 8'h0F, 1'b0));
    tbl.push_back(GUARD ? mk(DIV, 8'h00, 8'h05, 8'h00, 5, 2, 1, 8'h00, 8'hFF, 1'b1)
                        : mk(DIV, 8'h00, 8'h05, 8'h00, 14, 2, 0, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(DIV, 8'h01, 8'h23, 8'h45, 14, 2, 1, 8'h0F, 8'h04, 1'b0));

    reset   = 1'b0;
    start   = 1'b0;
    op_code = 2'b00;
    inbus   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outbus", outbus, 0);
    check("reset end", done, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // back-to-back: each vector starts in the cycle right after the previous END
    foreach (tbl[i]) run_vec(i, tbl[i]);

    // reset in cycle 5 of a multiply
    start   = 1'b1;
    op_code = MUL;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      inbus = (c == 1) ? 8'hFD : (c == 2) ? 8'h05 : 8'h00;
      if (c == 4) check("mid-mul busy", busy, 1);
    end
    reset = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset end", done, 0);
    check("async reset outbus", outbus, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("no END after reset c%0d", c), done, 0);
    end
    run_vec(100, mk(ADD, 8'h01, 8'h02, 8'h00, 4, 1, 1, 8'h03, 8'h00, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
